// File: rtl/sync_filter_pkg.sv
// Shared defaults, legal minimums and helpers for the input-conditioning blocks.
package sync_filter_pkg;

   localparam int STAGES_DEF = 2;
   localparam int FILT_DEF   = 4;
   localparam int STAGES_MIN = 2;
   localparam int FILT_MIN   = 1;

   // Per-edge filter action: hold, count another mismatch, or take the new level
   typedef enum logic [1:0] {
      FILT_STABLE,
      FILT_PENDING,
      FILT_ACCEPT
   } filt_e;

   // clog2 with a floor of 1 bit so FILT=1 still gets a legal counter
   function automatic int cnt_width(input int filt);
      int w;
      w = 1;
      while ((1 << w) < filt) w++;
      return w;
   endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One conditioned channel: synchronizer chain, consecutive-sample glitch filter
// and registered rise/fall pulses aligned with the level change.
module sync_chan
   import sync_filter_pkg::*;
#(
   parameter int STAGES = STAGES_DEF,
   parameter int FILT   = FILT_DEF
) (
   input  logic clock,
   input  logic reset_n,
   input  logic in,
   output logic out,
   output logic rise,
   output logic fall
);

   localparam int CW = cnt_width(FILT);
   localparam logic [CW-1:0] CMAX = CW'(FILT - 1);

   if (STAGES < STAGES_MIN || FILT < FILT_MIN) begin : g_bad_param
      $fatal(1, "sync_chan: STAGES must be >= 2 and FILT >= 1");
   end

   logic [STAGES-1:0] sync;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_nxt;
   logic              sy;
   filt_e             act;

   assign sy = sync[STAGES-1];

   always_ff @(posedge clock) begin
      if (!reset_n) sync <= '0;
      else          sync <= {sync[STAGES-2:0], in};
   end

   // A return to the old level clears the count rather than pausing it
   always_comb begin
      act     = FILT_STABLE;
      cnt_nxt = '0;
      if (sy != out) begin
         if (cnt == CMAX) begin
            act = FILT_ACCEPT;
         end else begin
            act     = FILT_PENDING;
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt  <= '0;
         out  <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         rise <= (act == FILT_ACCEPT) &&  sy;
         fall <= (act == FILT_ACCEPT) && !sy;
         if (act == FILT_ACCEPT) out <= sy;
      end
   end

endmodule

// File: rtl/sync_filter.sv
// N independent conditioned channels for asynchronous inputs entering the clock domain.
module sync_filter
   import sync_filter_pkg::*;
#(
   parameter int N      = 1,
   parameter int STAGES = STAGES_DEF,
   parameter int FILT   = FILT_DEF
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:N] in,
   output logic [1:N] out,
   output logic [1:N] rise,
   output logic [1:N] fall
);

   for (genvar i = 1; i <= N; i++) begin : g_chan
      sync_chan #(
         .STAGES (STAGES),
         .FILT   (FILT)
      ) u_chan (
         .clock   (clock),
         .reset_n (reset_n),
         .in      (in[i]),
         .out     (out[i]),
         .rise    (rise[i]),
         .fall    (fall[i])
      );
   end

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter: default config, a 3-channel FILT=2 instance
// and a STAGES=3/FILT=1 instance share clock and reset.
module tb_sync_filter;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:1] in_a, out_a, rise_a, fall_a;
   logic [1:3] in_b, out_b, rise_b, fall_b;
   logic [1:1] in_c, out_c, rise_c, fall_c;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   sync_filter dut_a (
      .clock (clock), .reset_n (reset_n), .in (in_a),
      .out (out_a), .rise (rise_a), .fall (fall_a)
   );

   sync_filter #(.N(3), .STAGES(2), .FILT(2)) dut_b (
      .clock (clock), .reset_n (reset_n), .in (in_b),
      .out (out_b), .rise (rise_b), .fall (fall_b)
   );

   sync_filter #(.N(1), .STAGES(3), .FILT(1)) dut_c (
      .clock (clock), .reset_n (reset_n), .in (in_c),
      .out (out_c), .rise (rise_c), .fall (fall_c)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic o, input logic r, input logic f);
      chk({tag, ".out"},  {3'b0, out_a},  {3'b0, o});
      chk({tag, ".rise"}, {3'b0, rise_a}, {3'b0, r});
      chk({tag, ".fall"}, {3'b0, fall_a}, {3'b0, f});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   logic [2:0] seq_b [0:4];
   logic [2:0] eo_b  [0:16];
   logic [2:0] er_b  [0:16];
   logic [2:0] ef_b  [0:16];

   initial begin
      // Reset held 3 cycles with all inputs high
      in_a = 1'b1; in_b = 3'b111; in_c = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_a("rst_hold", 1'b0, 1'b0, 1'b0);
         chk("rst_hold.b_out", {1'b0, out_b}, 4'h0);
      end
      reset_n = 1'b1;
      // edge j=1 is the first capture after release
      for (int j = 1; j <= 7; j++) begin
         step();
         chk_a("rst_release", j >= 6, j == 6, 1'b0);
         if (j == 4) begin
            chk("rst_release.c_rise", {3'b0, rise_c}, 4'h1);
            chk("rst_release.b_rise", {1'b0, rise_b}, 4'h7);
         end
      end

      in_a = 1'b0; in_b = 3'b000; in_c = 1'b0;
      do_reset();

      // Latency, default config
      in_a = 1'b1;
      for (int j = 1; j <= 7; j++) begin
         step();
         chk_a("lat_rise", j >= 6, j == 6, 1'b0);
      end
      in_a = 1'b0;
      for (int j = 1; j <= 7; j++) begin
         step();
         chk_a("lat_fall", j < 6, 1'b0, j == 6);
      end

      // Glitch of 3 samples is suppressed
      in_a = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         step();
         if (j == 3) in_a = 1'b0;
         chk_a("glitch3", 1'b0, 1'b0, 1'b0);
      end

      // 4 samples is accepted, then the return to 0 is accepted too
      in_a = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         step();
         if (j == 4) in_a = 1'b0;
         chk_a("pulse4", (j >= 6) && (j <= 9), j == 6, j == 10);
      end

      // Multi-channel, FILT=2: value sequence 0,1,2,3,0 held 3 captures each
      seq_b = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      eo_b = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
               3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010,
               3'b011, 3'b011, 3'b011, 3'b000, 3'b000};
      er_b = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
               3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000,
               3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
      ef_b = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
               3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000,
               3'b000, 3'b000, 3'b000, 3'b011, 3'b000};
      for (int j = 0; j <= 16; j++) begin
         in_b = (j < 15) ? seq_b[j / 3] : 3'd0;
         step();
         chk("multi.out",  {1'b0, out_b},  {1'b0, eo_b[j]});
         chk("multi.rise", {1'b0, rise_b}, {1'b0, er_b[j]});
         chk("multi.fall", {1'b0, fall_b}, {1'b0, ef_b[j]});
      end

      // Reset during PENDING discards the count
      in_a = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         step();
         chk_a("mid_pend", 1'b0, 1'b0, 1'b0);
      end
      reset_n = 1'b0;
      for (int j = 1; j <= 2; j++) begin
         step();
         chk_a("mid_rst", 1'b0, 1'b0, 1'b0);
      end
      reset_n = 1'b1;
      for (int j = 1; j <= 7; j++) begin
         step();
         chk_a("mid_after", j >= 6, j == 6, 1'b0);
      end

      // STAGES=3, FILT=1: a single-cycle input pulse passes through
      in_c = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         step();
         in_c = 1'b0;
         chk("corner.out",  {3'b0, out_c},  {3'b0, j == 4});
         chk("corner.rise", {3'b0, rise_c}, {3'b0, j == 4});
         chk("corner.fall", {3'b0, fall_c}, {3'b0, j == 5});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
